// File: rtl/line_key_dispenser.sv
// rtl/line_key_dispenser.sv - per-line scramble key dispenser fed by a 256-bit DRBG
// Optional underrun_count output enabled by defining LINE_KEY_UNDERRUN_CNT_EN.
module line_key_dispenser #(
   parameter int KEY_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   output logic                 init,
   input  logic                 init_ready,
   output logic                 next_bits,
   input  logic                 next_bits_ready,
   input  logic [255:0]         random_bits,
   input  logic                 line_start,
   output logic [KEY_WIDTH-1:0] key_out,
   output logic                 key_valid,
   output logic                 underrun,
`ifdef LINE_KEY_UNDERRUN_CNT_EN
   output logic [15:0]          underrun_count,
`endif
   output logic                 keys_ready
);

   localparam int WORDS = 256 / KEY_WIDTH;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {S_INIT, S_REQ, S_ACK, S_IDLE} state_t;

   state_t               state_q, state_d;
   logic                 init_q, init_d;
   logic                 next_bits_q, next_bits_d;
   logic [255:0]         fill_q, fill_d;
   logic                 fill_valid_q, fill_valid_d;
   logic [255:0]         act_q, act_d;
   logic                 act_valid_q, act_valid_d;
   logic [IDX_W-1:0]     index_q, index_d;
   logic [KEY_WIDTH-1:0] key_out_q, key_out_d;
   logic                 key_valid_q, key_valid_d;
   logic                 underrun_q, underrun_d;
   logic [KEY_WIDTH-1:0] key_sel;

   always_comb begin
      key_sel = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (index_q == IDX_W'(i)) key_sel = act_q[i*KEY_WIDTH +: KEY_WIDTH];
      end
   end

   always_comb begin
      state_d      = state_q;
      init_d       = 1'b0;
      next_bits_d  = next_bits_q;
      fill_d       = fill_q;
      fill_valid_d = fill_valid_q;
      act_d        = act_q;
      act_valid_d  = act_valid_q;
      index_d      = index_q;
      key_out_d    = key_out_q;
      key_valid_d  = 1'b0;
      underrun_d   = 1'b0;

      // DRBG handshake: next_bits is raised on entry to S_REQ so it is registered like every output
      case (state_q)
         S_INIT: begin
            init_d = ~init_ready;
            if (init_ready) begin
               state_d     = S_REQ;
               next_bits_d = 1'b1;
            end
         end
         S_REQ: begin
            if (next_bits_ready && !fill_valid_q) begin
               fill_d       = random_bits;
               fill_valid_d = 1'b1;
               next_bits_d  = 1'b0;
               state_d      = S_ACK;
            end else begin
               next_bits_d  = ~fill_valid_q;
            end
         end
         S_ACK: begin
            next_bits_d = 1'b0;
            if (!next_bits_ready) state_d = S_IDLE;
         end
         default: begin
            next_bits_d = 1'b0;
            if (!fill_valid_q) begin
               state_d     = S_REQ;
               next_bits_d = 1'b1;
            end
         end
      endcase

      // A move only happens while active is empty, so a coincident line_start underruns
      if (!act_valid_q && fill_valid_q) begin
         act_d        = fill_q;
         act_valid_d  = 1'b1;
         index_d      = '0;
         fill_valid_d = 1'b0;
      end

      if (line_start) begin
         if (act_valid_q) begin
            key_out_d   = key_sel;
            key_valid_d = 1'b1;
            if (index_q == IDX_W'(WORDS - 1)) begin
               act_valid_d = 1'b0;
               index_d     = '0;
            end else begin
               index_d     = index_q + IDX_W'(1);
            end
         end else begin
            underrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_INIT;
         init_q       <= 1'b0;
         next_bits_q  <= 1'b0;
         fill_q       <= '0;
         fill_valid_q <= 1'b0;
         act_q        <= '0;
         act_valid_q  <= 1'b0;
         index_q      <= '0;
         key_out_q    <= '0;
         key_valid_q  <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_q       <= init_d;
         next_bits_q  <= next_bits_d;
         fill_q       <= fill_d;
         fill_valid_q <= fill_valid_d;
         act_q        <= act_d;
         act_valid_q  <= act_valid_d;
         index_q      <= index_d;
         key_out_q    <= key_out_d;
         key_valid_q  <= key_valid_d;
         underrun_q   <= underrun_d;
      end
   end

`ifdef LINE_KEY_UNDERRUN_CNT_EN
   logic [15:0] ucnt_q, ucnt_d;

   always_comb begin
      ucnt_d = ucnt_q;
      if (underrun_d && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ucnt_q <= 16'd0;
      else          ucnt_q <= ucnt_d;
   end

   assign underrun_count = ucnt_q;
`endif

   assign init       = init_q;
   assign next_bits  = next_bits_q;
   assign key_out    = key_out_q;
   assign key_valid  = key_valid_q;
   assign underrun   = underrun_q;
   assign keys_ready = act_valid_q;

endmodule
